// File: rtl/hmr_tmr_group_ctrl.sv
// Lockstep entry/exit and setback-based resync controller for one TMR group of three cores.
// Also keeps saturating per-core single-fault counters and a multi-core (uncorrectable) counter.
module hmr_tmr_group_ctrl #(
   parameter int unsigned SetbackCycles = 4,
   parameter int unsigned CntWidth      = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         tmr_en_i,
   input  logic                         clear_cnt_i,
   input  logic [2:0]                   core_busy_i,
   input  logic [2:0]                   error_cba_i,
   output logic                         tmr_active_o,
   output logic [2:0]                   setback_o,
   output logic [1:0]                   state_o,
   output logic [2:0][CntWidth-1:0]     fault_cnt_o,
   output logic [CntWidth-1:0]          unc_cnt_o,
   output logic                         fault_irq_o
);

   localparam int unsigned TW = (SetbackCycles > 1) ? $clog2(SetbackCycles) : 1;
   localparam logic [TW-1:0] TimerLoad = TW'(SetbackCycles - 1);

   if (SetbackCycles == 0) begin : g_bad_setback
      $fatal(1, "hmr_tmr_group_ctrl: SetbackCycles must be at least 1");
   end

   typedef enum logic [1:0] {
      NON_TMR  = 2'd0,
      SETBACK  = 2'd1,
      TMR_RUN  = 2'd2,
      TMR_EXIT = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          monitor;
   logic          single_err;
   logic          multi_err;

   // Voter flags only matter while the voted path is live and not being resynchronised.
   assign monitor    = (state_q == TMR_RUN) || (state_q == TMR_EXIT);
   assign single_err = monitor && $onehot(error_cba_i);
   assign multi_err  = monitor && !$onehot0(error_cba_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= NON_TMR;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      unique case (state_q)
         NON_TMR: begin
            if (tmr_en_i && (core_busy_i == 3'b000)) begin
               state_d = SETBACK;
               timer_d = TimerLoad;
            end
         end
         SETBACK: begin
            if (timer_q == '0) begin
               state_d = tmr_en_i ? TMR_RUN : TMR_EXIT;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         TMR_RUN: begin
            if (single_err || multi_err) begin
               state_d = SETBACK;
               timer_d = TimerLoad;
            end else if (!tmr_en_i) begin
               state_d = TMR_EXIT;
            end
         end
         TMR_EXIT: begin
            // A renewed request wins over draining: the group never left lockstep.
            if (tmr_en_i) begin
               state_d = TMR_RUN;
            end else if (core_busy_i == 3'b000) begin
               state_d = NON_TMR;
            end
         end
         default: state_d = NON_TMR;
      endcase
   end

   always_comb begin
      tmr_active_o = (state_q != NON_TMR);
      setback_o    = (state_q == SETBACK) ? 3'b111 : 3'b000;
      state_o      = state_q;
   end

   // Clear takes effect first, so a same-cycle fault leaves the counter at one.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fault_cnt_o <= '0;
         unc_cnt_o   <= '0;
         fault_irq_o <= 1'b0;
      end else begin
         fault_irq_o <= single_err || multi_err;
         for (int k = 0; k < 3; k++) begin
            if (clear_cnt_i) begin
               fault_cnt_o[k] <= (single_err && error_cba_i[k]) ? CntWidth'(1) : '0;
            end else if (single_err && error_cba_i[k] && (fault_cnt_o[k] != '1)) begin
               fault_cnt_o[k] <= fault_cnt_o[k] + CntWidth'(1);
            end
         end
         if (clear_cnt_i) begin
            unc_cnt_o <= multi_err ? CntWidth'(1) : '0;
         end else if (multi_err && (unc_cnt_o != '1)) begin
            unc_cnt_o <= unc_cnt_o + CntWidth'(1);
         end
      end
   end

endmodule
